// File: rtl/sync_debounce_n.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce_n
// Description : Multi-channel input conditioner. Each raw input is passed
//               through a flop synchroniser, debounced by a per-channel
//               stability counter, and edge-detected into registered
//               RISE/FALL strobes plus an any-channel CHANGED flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce_n #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             ACLR_L,
  input  logic [WIDTH-1:0] ASYNC,
  output logic [WIDTH-1:0] SYNC,
  output logic [WIDTH-1:0] DEB,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // Count value at which the next differing cycle commits the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Stage 0 is the capture flop; stage STAGES-1 is the synchronised level.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            deb_q, deb_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;

  logic [WIDTH-1:0] sync_lvl;
  assign sync_lvl = sync_q[STAGES-1];

  // Synchroniser shift chain, new sample enters at stage 0.
  always_ff @(posedge CLK) begin
    if (!ACLR_L) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], ASYNC};
    end
  end

  // Per-channel debounce: count consecutive disagreeing cycles, commit on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_lvl[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]  = sync_lvl[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_lvl[i];
          fall_d[i] = ~sync_lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        // Level agrees again: any partial count was a glitch.
        cnt_d[i] = '0;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // Debounce state and strobe registers; reset clears without producing strobes.
  always_ff @(posedge CLK) begin
    if (!ACLR_L) begin
      cnt_q     <= '0;
      deb_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign SYNC    = sync_lvl;
  assign DEB     = deb_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign CHANGED = changed_q;

endmodule
`default_nettype wire
